rr_chip_select_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 3-to-8 chip-select decoder among 8 requesters.

---
 rtl/arb_pkg.sv | 32 +++
 rtl/grant_decoder_3to8.sv | 18 +
 rtl/rr_chip_select_arbiter.sv | 91 +++++++++
 tb/tb_rr_chip_select_arbiter.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, constants and round-robin pick for the chip-select arbiter
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Scan last_id+1, last_id+2, ... wrapping, with last_id itself checked last,
    // so the previous owner only wins again when nobody else is asking.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [ID_W-1:0]  last_id);
        logic [ID_W-1:0] id;
        logic [ID_W-1:0] cand;
        logic            found;
        id    = last_id;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = last_id + ID_W'(i);
            if (!found && req[cand]) begin
                id    = cand;
                found = 1'b1;
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/grant_decoder_3to8.sv
// rtl/grant_decoder_3to8.sv - enabled 3-to-8 one-hot chip-select decoder
module grant_decoder_3to8
    import arb_pkg::*;
(
    input  logic             en,
    input  logic [ID_W-1:0]  sel,
    output logic [N_REQ-1:0] y
);

    // Single select line when enabled, all lines low otherwise.
    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_chip_select_arbiter.sv
// rtl/rr_chip_select_arbiter.sv - round-robin owner selection driving a shared chip-select decoder
module rr_chip_select_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int              HC_W      = $clog2(MAX_HOLD);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    arb_state_t      state, state_n;
    logic [ID_W-1:0] id_q, id_n;
    logic [ID_W-1:0] last_id, last_id_n;
    logic [HC_W-1:0] hold_cnt, hold_n;
    logic            timeout_q, timeout_n;
    logic            normal_exit;
    logic            forced_exit;

    // Owner finishing or withdrawing always wins over the hold limit, so no timeout then.
    assign normal_exit = done || !req[id_q];
    assign forced_exit = (hold_cnt == HOLD_LAST);

    // State register and bookkeeping; reset mid-grant drops gnt with no GAP or pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            id_q      <= '0;
            last_id   <= ID_W'(N_REQ - 1);
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_n;
            id_q      <= id_n;
            last_id   <= last_id_n;
            hold_cnt  <= hold_n;
            timeout_q <= timeout_n;
        end
    end

    // Next-state: arbitrate from IDLE/GAP, hold in GRANT until done, drop or limit.
    always_comb begin
        state_n   = state;
        id_n      = id_q;
        last_id_n = last_id;
        hold_n    = hold_cnt;
        timeout_n = 1'b0;
        case (state)
            IDLE, GAP: begin
                if (|req) begin
                    state_n = GRANT;
                    id_n    = rr_pick(req, last_id);
                    hold_n  = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            GRANT: begin
                if (normal_exit || forced_exit) begin
                    state_n   = GAP;
                    last_id_n = id_q;
                    timeout_n = !normal_exit;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_n = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign gnt_valid = (state == GRANT);
    assign gnt_id    = id_q;
    assign timeout   = timeout_q;

    grant_decoder_3to8 u_dec (
        .en  (gnt_valid),
        .sel (id_q),
        .y   (gnt)
    );

endmodule

// File: tb/tb_rr_chip_select_arbiter.sv
// tb/tb_rr_chip_select_arbiter.sv - directed vector bench for the round-robin chip-select arbiter
module tb_rr_chip_select_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic       valid;
        logic [2:0] id;
        logic       tmo;
    } vec_t;

    vec_t vq[$];

    rr_chip_select_arbiter #(.MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs change at negedge; outputs sampled at the following negedge.
    task automatic step(input logic r, input logic [7:0] q, input logic d);
        rst  = r;
        req  = q;
        done = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void add(input logic r, input logic [7:0] q, input logic d,
                                input logic [7:0] g, input logic v, input logic [2:0] id,
                                input logic t);
        vec_t e;
        e.rst = r; e.req = q; e.done = d; e.gnt = g; e.valid = v; e.id = id; e.tmo = t;
        vq.push_back(e);
    endfunction

    // Structural invariants on every sampled cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(gnt)) begin
                errors++;
                $display("FAIL onehot0: gnt %h", gnt);
            end
            checks++;
            if (gnt !== (gnt_valid ? (8'h01 << gnt_id) : 8'h00)) begin
                errors++;
                $display("FAIL gnt_vs_id: gnt %h id %0d valid %b", gnt, gnt_id, gnt_valid);
            end
        end
    end

    initial begin
        rst = 1'b1; req = 8'h00; done = 1'b0;

        // idle after reset
        add(1, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        for (int i = 0; i < 5; i++) add(0, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        // 0x81 alternation
        add(1, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        add(0, 8'h81, 0, 8'h01, 1, 3'd0, 0);
        add(0, 8'h81, 1, 8'h00, 0, 3'd0, 0);
        add(0, 8'h81, 0, 8'h80, 1, 3'd7, 0);
        add(0, 8'h81, 0, 8'h80, 1, 3'd7, 0);
        add(0, 8'h81, 1, 8'h00, 0, 3'd0, 0);
        add(0, 8'h81, 0, 8'h01, 1, 3'd0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        // owner 3 drops its request
        add(0, 8'h08, 0, 8'h08, 1, 3'd3, 0);
        add(0, 8'h08, 0, 8'h08, 1, 3'd3, 0);
        add(0, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        add(0, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        // reset mid-grant, then last_id back to 7 (0x60 -> 5, not 6)
        add(0, 8'h20, 0, 8'h20, 1, 3'd5, 0);
        add(1, 8'h20, 0, 8'h00, 0, 3'd0, 0);
        add(0, 8'h20, 0, 8'h20, 1, 3'd5, 0);
        add(0, 8'h20, 1, 8'h00, 0, 3'd0, 0);
        add(1, 8'h00, 0, 8'h00, 0, 3'd0, 0);
        add(0, 8'h60, 0, 8'h20, 1, 3'd5, 0);
        add(0, 8'h00, 0, 8'h00, 0, 3'd0, 0);

        step(1, 8'h00, 0);
        mon_en = 1'b1;

        for (int k = 0; k < vq.size(); k++) begin
            step(vq[k].rst, vq[k].req, vq[k].done);
            chk($sformatf("v%0d gnt", k), gnt, vq[k].gnt);
            chk($sformatf("v%0d valid", k), {7'b0, gnt_valid}, {7'b0, vq[k].valid});
            chk($sformatf("v%0d timeout", k), {7'b0, timeout}, {7'b0, vq[k].tmo});
            if (vq[k].valid || vq[k].rst)
                chk($sformatf("v%0d id", k), {5'b0, gnt_id}, {5'b0, vq[k].id});
        end

        // forced release after 16 cycles, then done coinciding with the limit
        step(1, 8'h00, 0);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h04, 0);
            chk($sformatf("hold c%0d gnt", i), gnt, 8'h04);
            chk($sformatf("hold c%0d timeout", i), {7'b0, timeout}, 8'h00);
        end
        step(0, 8'h04, 0);
        chk("forced gap gnt", gnt, 8'h00);
        chk("forced gap timeout", {7'b0, timeout}, 8'h01);
        step(0, 8'h04, 0);
        chk("regrant gnt", gnt, 8'h04);
        chk("regrant timeout", {7'b0, timeout}, 8'h00);
        for (int i = 0; i < 15; i++) begin
            step(0, 8'h04, 0);
            chk($sformatf("hold2 c%0d gnt", i), gnt, 8'h04);
        end
        step(0, 8'h04, 1);
        chk("done at limit gnt", gnt, 8'h00);
        chk("done at limit timeout", {7'b0, timeout}, 8'h00);
        step(0, 8'h00, 0);
        chk("after limit idle gnt", gnt, 8'h00);

        // full rotation with one-cycle tenures
        step(1, 8'h00, 0);
        step(0, 8'hFF, 0);
        chk("rot first id", {5'b0, gnt_id}, 8'h00);
        chk("rot first gnt", gnt, 8'h01);
        for (int k = 1; k <= 8; k++) begin
            step(0, 8'hFF, 1);
            chk($sformatf("rot gap%0d gnt", k), gnt, 8'h00);
            chk($sformatf("rot gap%0d valid", k), {7'b0, gnt_valid}, 8'h00);
            step(0, 8'hFF, 0);
            chk($sformatf("rot g%0d gnt", k), gnt, 8'h01 << (k % 8));
            chk($sformatf("rot g%0d id", k), {5'b0, gnt_id}, 8'(k % 8));
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
